// File: rtl/vga_timing_pkg.sv
// Shared timing types, raster presets and total-length helpers for the video timing generator.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned front;
        int unsigned width;
        int unsigned back;
    } timing_t;

    typedef struct packed {
        timing_t h;
        timing_t v;
    } raster_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic ls;
        logic fs;
    } sync_flags_t;

    function automatic int unsigned htotal(input timing_t t);
        return t.active + t.front + t.width + t.back;
    endfunction

    function automatic int unsigned vtotal(input timing_t t);
        return t.active + t.front + t.width + t.back;
    endfunction

    localparam raster_t VGA_640x480 = '{
        h: '{active: 640, front: 16, width: 96, back: 48},
        v: '{active: 480, front: 10, width: 2,  back: 33}
    };

    localparam raster_t SVGA_800x600 = '{
        h: '{active: 800, front: 40, width: 128, back: 88},
        v: '{active: 600, front: 1,  width: 4,   back: 23}
    };

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Enable-gated shift register with async reset; DEPTH=0 degenerates to a wire.
module sync_delay_line #(
    parameter int unsigned W       = 1,
    parameter int unsigned DEPTH   = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, en};
            assign q = d;
        end else begin : g_shift
            logic [W-1:0] stages [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned i = 0; i < DEPTH; i++) stages[i] <= RST_VAL;
                end else if (en) begin
                    stages[0] <= d;
                    for (int unsigned i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
                end
            end

            assign q = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running H/V raster counters with sync, display-enable and line/frame markers,
// delayed through an optional pipeline so they align with downstream pixel data.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned HACTIVE  = 640,
    parameter int unsigned HFRONT   = 16,
    parameter int unsigned HWIDTH   = 96,
    parameter int unsigned HBACK    = 48,
    parameter int unsigned VACTIVE  = 480,
    parameter int unsigned VFRONT   = 10,
    parameter int unsigned VWIDTH   = 2,
    parameter int unsigned VBACK    = 33,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned PIPE_DLY = 0,
    parameter int unsigned CNT_W    = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    output logic [CNT_W-1:0] HCNT,
    output logic [CNT_W-1:0] VCNT,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             DE,
    output logic             LINE_START,
    output logic             FRAME_START
);

    localparam timing_t     HT     = '{active: HACTIVE, front: HFRONT, width: HWIDTH, back: HBACK};
    localparam timing_t     VT     = '{active: VACTIVE, front: VFRONT, width: VWIDTH, back: VBACK};
    localparam int unsigned HTOTAL = htotal(HT);
    localparam int unsigned VTOTAL = vtotal(VT);

    generate
        if (HACTIVE == 0 || HWIDTH == 0 || VACTIVE == 0 || VWIDTH == 0) begin : g_err_zero
            $error("vga_timing_gen: ACTIVE and WIDTH parameters must be non-zero");
        end
        if (HBACK == 0 || VBACK == 0) begin : g_err_back
            $error("vga_timing_gen: back porch must be non-zero so sync ends before the wrap");
        end
        if (PIPE_DLY > 15) begin : g_err_dly
            $error("vga_timing_gen: PIPE_DLY must be 0..15");
        end
        if ((64'(1) << CNT_W) < 64'(HTOTAL) || (64'(1) << CNT_W) < 64'(VTOTAL)) begin : g_err_cnt
            $error("vga_timing_gen: CNT_W too small for HTOTAL/VTOTAL");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(HACTIVE);
    localparam logic [CNT_W-1:0] HS0    = CNT_W'(HACTIVE + HFRONT);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(HACTIVE + HFRONT + HWIDTH);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HTOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(VACTIVE);
    localparam logic [CNT_W-1:0] VS0    = CNT_W'(VACTIVE + VFRONT);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(VACTIVE + VFRONT + VWIDTH);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VTOTAL - 1);

    logic        h_wrap;
    logic        v_wrap;
    logic        vs_q;
    logic        vs_next;
    sync_flags_t dec;
    sync_flags_t dly;

    assign h_wrap = (HCNT == H_LAST);
    assign v_wrap = (VCNT == V_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            HCNT <= '0;
            VCNT <= '0;
            vs_q <= 1'b0;
        end else if (EN) begin
            HCNT <= h_wrap ? '0 : HCNT + CNT_W'(1);
            if (h_wrap) VCNT <= v_wrap ? '0 : VCNT + CNT_W'(1);
            vs_q <= vs_next;
        end
    end

    // The next-state of the vs register is fed down the pipe instead of vs_q itself,
    // so VS travels with the hs decode of the same HCNT and both edges coincide.
    always_comb begin
        vs_next = vs_q;
        if (HCNT == HS0 && VCNT == VS0)         vs_next = 1'b1;
        else if (HCNT == HS0 && VCNT == VS_END) vs_next = 1'b0;

        dec    = '0;
        dec.hs = (HCNT >= HS0) && (HCNT < HS_END);
        dec.vs = vs_next;
        dec.de = (HCNT < H_ACT) && (VCNT < V_ACT);
        dec.ls = (HCNT == '0);
        dec.fs = (HCNT == '0) && (VCNT == '0);
    end

    sync_delay_line #(
        .W       ($bits(sync_flags_t)),
        .DEPTH   (PIPE_DLY),
        .RST_VAL ('0)
    ) u_delay (
        .clk (CLK),
        .rst (RST),
        .en  (EN),
        .d   (dec),
        .q   (dly)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
            DE          <= 1'b0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else if (EN) begin
            VGA_HS      <= dly.hs ? HS_POL : ~HS_POL;
            VGA_VS      <= dly.vs ? VS_POL : ~VS_POL;
            DE          <= dly.de;
            LINE_START  <= dly.ls;
            FRAME_START <= dly.fs;
        end
    end

endmodule
